btn_cmd_queue: RTL

Converts debounced button activity into a queue of discrete move commands for the game logic. Sits directly downstream of the four per-button debouncers (up, down, left, right). Each press emits one command. Holding the most recently pressed button emits repeats after an initial delay. Commands are buffered in a small FIFO and drained over a valid/ready handshake.

---
 rtl/btn_pkg.sv | 31 +++
 rtl/cmd_fifo.sv | 65 ++++++
 rtl/btn_cmd_queue.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared types and default timing constants for the button command queue.
//   dir_t        : move direction, also the FIFO payload encoding
//   hold_state_t : states of the hold/auto-repeat tracker
// -----------------------------------------------------------------------------
package btn_pkg;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      HS_IDLE   = 2'd0,
      HS_DELAY  = 2'd1,
      HS_REPEAT = 2'd2
   } hold_state_t;

   // 500 ms first-repeat delay and 100 ms repeat period at 100 MHz.
   localparam int DEF_DELAY_CYC  = 50_000_000;
   localparam int DEF_REPEAT_CYC = 10_000_000;
   localparam int DEF_DEPTH      = 4;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// -----------------------------------------------------------------------------
// cmd_fifo
// Small synchronous FIFO holding queued move commands.
//   clk, rst   : clock, synchronous active-high reset
//   i_push     : write request, i_data is stored if accepted
//   i_data     : write data
//   i_pop      : read request, honoured only when not empty
//   o_accept   : the push of this cycle is being stored
//   o_full     : all DEPTH entries occupied
//   o_empty    : no entries
//   o_head     : oldest entry, read straight from the storage registers
// Pointers carry one extra bit so full (MSBs differ, rest equal) and empty
// (all bits equal) are distinguishable without a separate counter.
// -----------------------------------------------------------------------------
module cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_pop,
   output logic         o_accept,
   output logic         o_full,
   output logic         o_empty,
   output logic [W-1:0] o_head
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  r_wr;
   logic [AW:0]  r_rd;
   logic [W-1:0] r_mem [DEPTH];

   logic w_do_pop;
   logic w_do_push;

   assign o_empty   = (r_wr == r_rd);
   assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign w_do_pop  = i_pop && !o_empty;
   // A pop in the same cycle frees the slot a push into a full FIFO needs.
   assign w_do_push = i_push && (!o_full || w_do_pop);
   assign o_accept  = w_do_push;
   assign o_head    = r_mem[r_rd[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr <= '0;
         r_rd <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_do_push) begin
            r_mem[r_wr[AW-1:0]] <= i_data;
            r_wr                <= r_wr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd <= r_rd + 1'b1;
         end
      end
   end

endmodule

// File: rtl/btn_cmd_queue.sv
// -----------------------------------------------------------------------------
// btn_cmd_queue
// Turns debounced button activity into queued move commands: one per press,
// plus auto-repeats while the most recently pressed button is held.
//   clk, rst   : clock, synchronous active-high reset
//   btn_lvl    : debounced levels, [0]=up [1]=down [2]=left [3]=right
//   btn_dn     : one-cycle press pulses, same bit order
//   cmd_valid  : queue head is valid
//   cmd_dir    : head direction (dir_t encoding)
//   cmd_ready  : consumer accepts the head
//   dropped    : sticky, an event was lost (multi-press loser or full queue)
//   dbg_state  : current hold tracker state
// Handshake: a command transfers in every cycle where cmd_valid and cmd_ready
// are both high; while cmd_valid is high and cmd_ready low, cmd_dir holds.
// -----------------------------------------------------------------------------
module btn_cmd_queue
   import btn_pkg::*;
#(
   parameter int DELAY_CYC  = DEF_DELAY_CYC,
   parameter int REPEAT_CYC = DEF_REPEAT_CYC,
   parameter int DEPTH      = DEF_DEPTH
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  btn_lvl,
   input  logic [3:0]  btn_dn,
   output logic        cmd_valid,
   output logic [1:0]  cmd_dir,
   input  logic        cmd_ready,
   output logic        dropped,
   output hold_state_t dbg_state
);

   localparam int          CW       = $clog2(max_int(DELAY_CYC, REPEAT_CYC));
   localparam logic [CW-1:0] DLY_LAST = CW'(DELAY_CYC - 1);
   localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CYC - 1);

   hold_state_t   r_state, w_state_nxt;
   dir_t          r_trk_dir, w_trk_dir_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic          r_dropped;

   dir_t w_win_dir;
   logic w_press;
   logic w_multi;
   logic w_repeat;
   logic w_push;
   dir_t w_push_dir;
   logic w_accept;
   logic w_full;
   logic w_empty;
   logic w_pop;

   assign w_press = |btn_dn;
   // Clearing the lowest set bit leaves something only if two or more were set.
   assign w_multi = (btn_dn & (btn_dn - 4'd1)) != 4'd0;

   always_comb begin
      w_win_dir = DIR_UP;
      if (btn_dn[0])      w_win_dir = DIR_UP;
      else if (btn_dn[1]) w_win_dir = DIR_DOWN;
      else if (btn_dn[2]) w_win_dir = DIR_LEFT;
      else if (btn_dn[3]) w_win_dir = DIR_RIGHT;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= HS_IDLE;
         r_trk_dir <= DIR_UP;
         r_cnt     <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_trk_dir <= w_trk_dir_nxt;
         r_cnt     <= w_cnt_nxt;
      end
   end

   // Press beats everything; release is checked before expiry so the
   // release cycle never emits a repeat.
   always_comb begin
      w_state_nxt   = r_state;
      w_trk_dir_nxt = r_trk_dir;
      w_cnt_nxt     = r_cnt;
      w_repeat      = 1'b0;
      if (w_press) begin
         w_state_nxt   = HS_DELAY;
         w_trk_dir_nxt = w_win_dir;
         w_cnt_nxt     = '0;
      end else begin
         case (r_state)
            HS_DELAY, HS_REPEAT: begin
               if (!btn_lvl[r_trk_dir]) begin
                  w_state_nxt = HS_IDLE;
                  w_cnt_nxt   = '0;
               end else if ((r_state == HS_DELAY  && r_cnt == DLY_LAST) ||
                            (r_state == HS_REPEAT && r_cnt == REP_LAST)) begin
                  w_repeat    = 1'b1;
                  w_state_nxt = HS_REPEAT;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
            default: begin
               w_state_nxt = HS_IDLE;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   assign w_push     = w_press || w_repeat;
   assign w_push_dir = w_press ? w_win_dir : r_trk_dir;
   assign w_pop      = cmd_valid && cmd_ready;

   cmd_fifo #(
      .DEPTH (DEPTH),
      .W     (2)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .i_push   (w_push),
      .i_data   (w_push_dir),
      .i_pop    (w_pop),
      .o_accept (w_accept),
      .o_full   (w_full),
      .o_empty  (w_empty),
      .o_head   (cmd_dir)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_dropped <= 1'b0;
      end else if (w_multi || (w_push && !w_accept)) begin
         r_dropped <= 1'b1;
      end
   end

   assign cmd_valid = !w_empty;
   assign dropped   = r_dropped;
   assign dbg_state = r_state;

   // Kept for visibility on the sub-module boundary; full is implied by accept.
   logic w_unused;
   assign w_unused = w_full;

endmodule
